// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_pkg
// Brief    : Shared widths, state encoding and helpers for mult_share_arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mult_arb_pkg;

    localparam int OPW  = 8;
    localparam int RESW = 16;
    localparam logic [RESW-1:0] ERR_RESULT = 16'hFFFF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_START = S_START,
        ST_WAIT  = S_WAIT,
        ST_RESP  = S_RESP
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotating-priority picker; searches from rr_ptr.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [idx_w(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]        gnt,
    output logic [idx_w(N_REQ)-1:0] gnt_idx
);

    localparam int IW = idx_w(N_REQ);
    localparam logic [IW:0] C_N = (IW+1)'(N_REQ);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;
    logic          w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // rr_ptr < N_REQ, so one conditional subtract performs the wrap.
            w_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (w_sum >= C_N) begin
                w_sum = w_sum - C_N;
            end
            w_pos = w_sum[IW-1:0];
            if (!w_found && req[w_pos]) begin
                w_found      = 1'b1;
                gnt[w_pos]   = 1'b1;
                gnt_idx      = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Brief    : Round-robin sharing of one sequential 8x8 multiplier among N_REQ
//            clients. Optional WAIT timeout enabled by MULT_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [OPW*N_REQ-1:0]   mplier_in,
    input  logic [OPW*N_REQ-1:0]   mcand_in,
    output logic [N_REQ-1:0]       ack,
    output logic [RESW-1:0]        result_out,
    output logic                   err,
    output logic                   busy,
    output logic                   mul_st,
    output logic [OPW-1:0]         mul_mplier,
    output logic [OPW-1:0]         mul_mcand,
    input  logic                   mul_done,
    input  logic [RESW-1:0]        mul_result
);

    localparam int IW = idx_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_param_check
        $error("mult_share_arbiter: N_REQ or TIMEOUT_CYC out of range");
    end

    state_t            r_state, w_next;
    logic [IW-1:0]     r_rr_ptr, r_gidx, w_gidx;
    logic [N_REQ-1:0]  r_gnt, w_gnt;
    logic              r_wait_first;
    logic              w_done_ok, w_timeout;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gidx)
    );

    // A Done still high from the previous operation is ignored on the first WAIT cycle.
    assign w_done_ok = (r_state == ST_WAIT) && !r_wait_first && mul_done;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] r_wcnt;
    logic       r_err;

    assign w_timeout = (r_state == ST_WAIT) && !w_done_ok && (r_wcnt == C_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else if (r_state == ST_START) begin
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            r_wcnt <= r_wcnt + 8'd1;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic r_err;
    assign w_timeout = 1'b0;
    assign r_err     = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        busy   = (r_state != ST_IDLE);
        mul_st = (r_state == ST_START);
        ack    = '0;
        err    = 1'b0;
        case (r_state)
            ST_IDLE:  if (|req) w_next = ST_START;
            ST_START: w_next = ST_WAIT;
            ST_WAIT:  if (w_done_ok || w_timeout) w_next = ST_RESP;
            ST_RESP: begin
                ack    = r_gnt & req;
                err    = r_err;
                w_next = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_gidx       <= '0;
            r_gnt        <= '0;
            r_wait_first <= 1'b0;
            mul_mplier   <= '0;
            mul_mcand    <= '0;
            result_out   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (|req) begin
                    r_gidx     <= w_gidx;
                    r_gnt      <= w_gnt;
                    mul_mplier <= mplier_in[w_gidx*OPW +: OPW];
                    mul_mcand  <= mcand_in[w_gidx*OPW +: OPW];
                end
                ST_START: r_wait_first <= 1'b1;
                ST_WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_done_ok) begin
                        result_out <= mul_result;
                    end else if (w_timeout) begin
                        result_out <= ERR_RESULT;
                    end
                end
                ST_RESP: begin
                    if (r_gidx == IW'(N_REQ - 1)) r_rr_ptr <= '0;
                    else                          r_rr_ptr <= r_gidx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_arbiter
// Brief    : Scoreboard bench: per-requester expected-product queues, a
//            behavioural multiplier and randomized contending clients.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] mplier_in = '0;
    logic [8*N-1:0] mcand_in = '0;
    logic [N-1:0]   ack;
    logic [15:0]    result_out;
    logic           err, busy, mul_st;
    logic [7:0]     mul_mplier, mul_mcand;
    logic           mul_done;
    logic [15:0]    mul_result;

    always #5 clk = ~clk;

    mult_share_arbiter #(.N_REQ(N), .TIMEOUT_CYC(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mplier_in  (mplier_in),
        .mcand_in   (mcand_in),
        .ack        (ack),
        .result_out (result_out),
        .err        (err),
        .busy       (busy),
        .mul_st     (mul_st),
        .mul_mplier (mul_mplier),
        .mul_mcand  (mul_mcand),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t exp_q[N][$];
    int   ack_order[$];
    bit   ack_seen[N];
    int   wait_ops[N];
    int   checks = 0;
    int   failures = 0;
    int   nstarts = 0;
    logic prev_st = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, want);
        end
    endtask

    // Behavioural multiplier: Done from the previous op lingers one cycle after a start.
    logic [7:0] ma, mb;
    int         mcnt;
    bit         mpend, mstall;
    initial begin
        mul_done = 1'b0; mul_result = '0; mpend = 1'b0; mstall = 1'b0;
        ma = '0; mb = '0; mcnt = 0;
    end
    always @(posedge clk) begin
        if (mul_st) begin
            ma    <= mul_mplier;
            mb    <= mul_mcand;
            mcnt  <= $urandom_range(0, 5);
            mpend <= 1'b1;
        end else if (mpend) begin
            mul_done <= 1'b0;
            if (mcnt == 0) begin
                if (!mstall) begin
                    mul_done   <= 1'b1;
                    mul_result <= 16'(ma) * 16'(mb);
                    mpend      <= 1'b0;
                end
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mul_st) begin
                nstarts++;
                check("mul_st_single_cycle", 32'(prev_st), 0);
            end
            prev_st = mul_st;
            if (ack != '0) begin
                check("ack_onehot", 32'($onehot(ack)), 1);
                for (int i = 0; i < N; i++) begin
                    if (ack[i]) begin
                        ack_order.push_back(i);
                        ack_seen[i] = 1'b1;
                        if (exp_q[i].size() == 0) begin
                            checks++; failures++;
                            $display("FAIL ack_unexpected: requester %0d acked with no pending request", i);
                        end else begin
                            mon_e = exp_q[i].pop_front();
                            check($sformatf("result_r%0d", i), 32'(result_out), 32'(mon_e.res));
                            check($sformatf("err_r%0d", i), 32'(err), 32'(mon_e.err));
                        end
                        check($sformatf("fairness_r%0d", i), 32'(wait_ops[i] <= N-1), 1);
                        for (int j = 0; j < N; j++) begin
                            if (j != i && req[j]) wait_ops[j]++;
                        end
                    end
                end
            end
        end else begin
            prev_st = 1'b0;
        end
    end

    task automatic run_req(input int i, input logic [7:0] a, input logic [7:0] b, input bit exp_err = 1'b0);
        exp_t e;
        int   c;
        mplier_in[8*i +: 8] = a;
        mcand_in[8*i +: 8]  = b;
        e.res = exp_err ? 16'hFFFF : 16'(a) * 16'(b);
        e.err = exp_err;
        exp_q[i].push_back(e);
        wait_ops[i] = 0;
        ack_seen[i] = 1'b0;
        req[i] = 1'b1;
        c = 0;
        while (!ack_seen[i] && c < 1000) begin
            @(posedge clk);
            c++;
        end
        if (!ack_seen[i]) begin
            checks++; failures++;
            $display("FAIL ack_timeout_r%0d: no ack within 1000 cycles", i);
            exp_q[i].delete();
        end
        #1;
        req[i] = 1'b0;
        ack_seen[i] = 1'b0;
    endtask

    task automatic wait_st();
        int c = 0;
        while (!mul_st && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (!mul_st) begin
            checks++; failures++;
            $display("FAIL wait_mul_st: no start pulse within 300 cycles");
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        @(negedge clk);
        while (busy && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (busy) begin
            checks++; failures++;
            $display("FAIL wait_idle: still busy after 300 cycles");
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},    32'(ack), 0);
        check({tag, "_result"}, 32'(result_out), 0);
        check({tag, "_err"},    32'(err), 0);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_mul_st"}, 32'(mul_st), 0);
        check({tag, "_mplier"}, 32'(mul_mplier), 0);
        check({tag, "_mcand"},  32'(mul_mcand), 0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rnd_op();
        int sel = $urandom_range(0, 7);
        if (sel == 0) return 8'h00;
        if (sel == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    task automatic client(input int k);
        int n = $urandom_range(1, 3);
        repeat (n) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            run_req(k, rnd_op(), rnd_op());
        end
    endtask

    initial begin
        logic [7:0] wa, wb;
        int st0, cyc;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset in the middle of WAIT; the held request must be served afterwards.
        fork
            run_req(0, 8'd7, 8'd9);
            begin
                wait_st();
                @(posedge clk); #2 rst_n = 1'b0;
                #1 check_all_zero("midop_reset");
                @(posedge clk); #1 rst_n = 1'b1;
            end
        join

        // Single request; operands scrambled right after grant must be ignored.
        st0 = nstarts;
        ack_order.delete();
        fork
            run_req(1, 8'd10, 8'd5);
            begin
                wait_st();
                mplier_in[15:8] = 8'($urandom);
                mcand_in[15:8]  = 8'($urandom);
            end
        join
        check("single_start_count", 32'(nstarts - st0), 1);
        check("single_ack_index", 32'(ack_order.size() == 1 && ack_order[0] == 1), 1);

        // Full contention from a freshly reset pointer.
        apply_reset();
        ack_order.delete();
        fork
            run_req(0, 8'd1,  8'd2);
            run_req(1, 8'd17, 8'd18);
            run_req(2, 8'd33, 8'd34);
            run_req(3, 8'd49, 8'd50);
        join
        check("contention_count", 32'(ack_order.size()), 4);
        for (int i = 0; i < 4 && i < ack_order.size(); i++)
            check($sformatf("contention_order_%0d", i), 32'(ack_order[i]), 32'(i));
        check("contention_last_result", 32'(result_out), 32'd2450);

        // Wrap: move the pointer to 3, then requesters 3 and 0 together.
        run_req(2, rnd_op(), rnd_op());
        ack_order.delete();
        fork
            run_req(3, 8'd255, 8'd255);
            run_req(0, rnd_op(), rnd_op());
        join
        check("wrap_count", 32'(ack_order.size()), 2);
        if (ack_order.size() == 2) begin
            check("wrap_first", 32'(ack_order[0]), 3);
            check("wrap_second", 32'(ack_order[1]), 0);
        end

        // Withdraw during WAIT: no ack, but the result register still updates.
        ack_order.delete();
        wa = rnd_op(); wb = rnd_op();
        mplier_in[23:16] = wa;
        mcand_in[23:16]  = wb;
        req[2] = 1'b1;
        wait_st();
        @(posedge clk); #1 req[2] = 1'b0;
        wait_idle();
        check("withdraw_no_ack", 32'(ack_order.size()), 0);
        check("withdraw_result", 32'(result_out), 32'(16'(wa) * 16'(wb)));
        run_req(0, rnd_op(), rnd_op());

`ifdef MULT_ARB_TIMEOUT_EN
        mstall = 1'b1;
        fork
            run_req(1, 8'd3, 8'd4, 1'b1);
            begin
                wait_st();
                cyc = 0;
                while (!ack[1] && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                end
                check("timeout_latency", 32'(cyc), 65);
            end
        join
        check("timeout_back_to_idle", 32'(busy), 0);
        mstall = 1'b0;
`endif

        // Randomized contention.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                fork
                    automatic int k = i;
                    client(k);
                join_none
            end
            wait fork;
        end

        wait_idle();
        for (int i = 0; i < N; i++)
            check($sformatf("drained_r%0d", i), 32'(exp_q[i].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
